// File: rtl/ctrl_seq_pkg.sv
// Shared types and constants for the accumulator CPU instruction sequencer.
// The WAIT state only exists when CTRL_SEQ_STEP_EN is defined.
package ctrl_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_OPER,
    S_EXEC,
    S_HALT
`ifdef CTRL_SEQ_STEP_EN
    , S_WAIT
`endif
  } state_t;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_STA = 4'h2;
  localparam logic [3:0] OP_ADD = 4'h3;
  localparam logic [3:0] OP_SUB = 4'h4;
  localparam logic [3:0] OP_JMP = 4'h5;
  localparam logic [3:0] OP_JZ  = 4'h6;
  localparam logic [3:0] OP_HLT = 4'hF;

  localparam logic [1:0] ALU_PASS = 2'b00;
  localparam logic [1:0] ALU_ADD  = 2'b01;
  localparam logic [1:0] ALU_SUB  = 2'b10;

  // Strobes an instruction asserts during its EXEC cycle.
  typedef struct packed {
    logic       pc_inc;
    logic       pc_ld;
    logic       addr_sel;
    logic       mem_rd;
    logic       mem_wr;
    logic       acc_ld;
    logic       acc_oe;
    logic [1:0] alu_op;
  } exec_t;

endpackage

// File: rtl/ctrl_seq_dec.sv
// Combinational opcode decoder: instruction class flags and EXEC-cycle strobes.
module ctrl_seq_dec
  import ctrl_seq_pkg::*;
#(
  parameter int OPW = 4
) (
  input  logic [OPW-1:0] opcode,
  input  logic           acc_zero,
  output logic           is_two_byte,
  output logic           is_halt,
  output logic           is_illegal,
  output exec_t          ex
);

  always_comb begin
    is_two_byte = 1'b0;
    is_halt     = 1'b0;
    is_illegal  = 1'b0;
    ex          = '0;
    case (opcode)
      OPW'(OP_NOP): ;
      OPW'(OP_LDA), OPW'(OP_ADD), OPW'(OP_SUB): begin
        is_two_byte = 1'b1;
        ex.addr_sel = 1'b1;
        ex.mem_rd   = 1'b1;
        ex.acc_ld   = 1'b1;
        ex.pc_inc   = 1'b1;
        if (opcode == OPW'(OP_ADD))      ex.alu_op = ALU_ADD;
        else if (opcode == OPW'(OP_SUB)) ex.alu_op = ALU_SUB;
        else                             ex.alu_op = ALU_PASS;
      end
      OPW'(OP_STA): begin
        is_two_byte = 1'b1;
        ex.addr_sel = 1'b1;
        ex.mem_wr   = 1'b1;
        ex.acc_oe   = 1'b1;
        ex.pc_inc   = 1'b1;
      end
      OPW'(OP_JMP): begin
        is_two_byte = 1'b1;
        ex.pc_ld    = 1'b1;
      end
      // The only combinational input dependency of the sequencer outputs.
      OPW'(OP_JZ): begin
        is_two_byte = 1'b1;
        ex.pc_ld    = acc_zero;
        ex.pc_inc   = ~acc_zero;
      end
      OPW'(OP_HLT): is_halt = 1'b1;
      default:      is_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/ctrl_seq.sv
// Moore instruction sequencer for the 8-bit accumulator CPU.
// Optional single-step mode (step port + WAIT state) with CTRL_SEQ_STEP_EN.
//
// state    | meaning
// ---------+--------------------------------------------------------
// S_IDLE   | no strobes; waiting for run
// S_FETCH  | read opcode byte at PC into IR
// S_DECODE | advance PC past opcode; branch on instruction class
// S_OPER   | read address byte at PC into MAR
// S_EXEC   | per-opcode memory/accumulator/PC action
// S_HALT   | halted until rst
// S_WAIT   | (step mode) between instructions, waiting for step edge
module ctrl_seq
  import ctrl_seq_pkg::*;
#(
  parameter int OPW = 4,
  parameter int DW  = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          run,
  input  logic [DW-1:0] ir,
  input  logic          acc_zero,
`ifdef CTRL_SEQ_STEP_EN
  input  logic          step,
`endif
  output logic          pc_inc,
  output logic          pc_ld,
  output logic          ir_ld,
  output logic          mar_ld,
  output logic          addr_sel,
  output logic          mem_rd,
  output logic          mem_wr,
  output logic          acc_ld,
  output logic          acc_oe,
  output logic [1:0]    alu_op,
  output logic          halted,
  output logic          illegal
);

  state_t state;
  logic   is_two_byte;
  logic   is_halt;
  logic   is_illegal;
  exec_t  ex;
  logic   unused_ir;

  assign unused_ir = ^ir[DW-OPW-1:0];

  ctrl_seq_dec #(.OPW(OPW)) u_dec (
    .opcode      (ir[DW-1 -: OPW]),
    .acc_zero    (acc_zero),
    .is_two_byte (is_two_byte),
    .is_halt     (is_halt),
    .is_illegal  (is_illegal),
    .ex          (ex)
  );

`ifdef CTRL_SEQ_STEP_EN
  localparam state_t S_NEXT = S_WAIT;
  logic step_q;
  logic step_rise;

  assign step_rise = step & ~step_q;

  always_ff @(posedge clk) begin
    if (rst) step_q <= 1'b0;
    else     step_q <= step;
  end
`else
  localparam state_t S_NEXT = S_FETCH;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      illegal <= 1'b0;
    end else begin
      case (state)
        S_IDLE:   if (run) state <= S_FETCH;
        S_FETCH:  state <= S_DECODE;
        S_DECODE: begin
          if (is_halt || is_illegal) begin
            state <= S_HALT;
            if (is_illegal) illegal <= 1'b1;
          end else if (is_two_byte) begin
            state <= S_OPER;
          end else begin
            state <= S_NEXT;
          end
        end
        S_OPER:   state <= S_EXEC;
        S_EXEC:   state <= S_NEXT;
        S_HALT:   state <= S_HALT;
`ifdef CTRL_SEQ_STEP_EN
        S_WAIT:   if (step_rise) state <= S_FETCH;
`endif
        default:  state <= S_IDLE;
      endcase
    end
  end

  // PC-addressed cycles (FETCH, OPER) never increment the PC.
  always_comb begin
    pc_inc   = 1'b0;
    pc_ld    = 1'b0;
    ir_ld    = 1'b0;
    mar_ld   = 1'b0;
    addr_sel = 1'b0;
    mem_rd   = 1'b0;
    mem_wr   = 1'b0;
    acc_ld   = 1'b0;
    acc_oe   = 1'b0;
    alu_op   = ALU_PASS;
    case (state)
      S_FETCH: begin
        mem_rd = 1'b1;
        ir_ld  = 1'b1;
      end
      S_DECODE: pc_inc = 1'b1;
      S_OPER: begin
        mem_rd = 1'b1;
        mar_ld = 1'b1;
      end
      S_EXEC: begin
        pc_inc   = ex.pc_inc;
        pc_ld    = ex.pc_ld;
        addr_sel = ex.addr_sel;
        mem_rd   = ex.mem_rd;
        mem_wr   = ex.mem_wr;
        acc_ld   = ex.acc_ld;
        acc_oe   = ex.acc_oe;
        alu_op   = ex.alu_op;
      end
      default: ;
    endcase
  end

  assign halted = (state == S_HALT);

endmodule

// File: tb/tb_ctrl_seq.sv
// Self-checking bench for ctrl_seq: a phase-level model of the instruction
// rules predicts every output each cycle; literal pins anchor the model.
module tb_ctrl_seq;

  localparam int PH_IDLE = 0, PH_FETCH = 1, PH_DECODE = 2, PH_OPER = 3,
                 PH_EXEC = 4, PH_HALT = 5, PH_WAIT = 6;

  logic       clk = 1'b0;
  logic       rst, run, acc_zero;
  logic [7:0] ir;
  logic       pc_inc, pc_ld, ir_ld, mar_ld, addr_sel, mem_rd, mem_wr;
  logic       acc_ld, acc_oe, halted, illegal;
  logic [1:0] alu_op;
`ifdef CTRL_SEQ_STEP_EN
  logic       step;
`endif

  int          checks = 0;
  int          errors = 0;
  int          fetches = 0;
  logic        exp_on = 1'b0;
  logic [12:0] exp_vec = '0;
  logic        m_ill = 1'b0;
  logic [12:0] dut_vec;

  always #5 clk = ~clk;

  ctrl_seq dut (
    .clk      (clk),
    .rst      (rst),
    .run      (run),
    .ir       (ir),
    .acc_zero (acc_zero),
`ifdef CTRL_SEQ_STEP_EN
    .step     (step),
`endif
    .pc_inc   (pc_inc),
    .pc_ld    (pc_ld),
    .ir_ld    (ir_ld),
    .mar_ld   (mar_ld),
    .addr_sel (addr_sel),
    .mem_rd   (mem_rd),
    .mem_wr   (mem_wr),
    .acc_ld   (acc_ld),
    .acc_oe   (acc_oe),
    .alu_op   (alu_op),
    .halted   (halted),
    .illegal  (illegal)
  );

  assign dut_vec = {pc_inc, pc_ld, ir_ld, mar_ld, addr_sel, mem_rd, mem_wr,
                    acc_ld, acc_oe, alu_op, halted, illegal};

  // Expected outputs for one cycle of an instruction phase, from the ISA rules.
  function automatic logic [12:0] model(input int ph, input logic [7:0] op_byte,
                                        input logic az, input logic ill);
    logic [3:0] op;
    logic pi, pl, il, ml, as, rd, wr, al, ao, h;
    logic [1:0] alu;
    op = op_byte[7:4];
    {pi, pl, il, ml, as, rd, wr, al, ao, h} = '0;
    alu = 2'b00;
    case (ph)
      PH_FETCH:  begin rd = 1; il = 1; end
      PH_DECODE: pi = 1;
      PH_OPER:   begin rd = 1; ml = 1; end
      PH_EXEC: begin
        if (op == 4'h1 || op == 4'h3 || op == 4'h4) begin
          as = 1; rd = 1; al = 1; pi = 1;
          alu = (op == 4'h3) ? 2'b01 : (op == 4'h4) ? 2'b10 : 2'b00;
        end
        if (op == 4'h2) begin as = 1; wr = 1; ao = 1; pi = 1; end
        if (op == 4'h5) pl = 1;
        if (op == 4'h6) begin pl = az; pi = ~az; end
      end
      PH_HALT: h = 1;
      default: ;
    endcase
    return {pi, pl, il, ml, as, rd, wr, al, ao, alu, h, ill};
  endfunction

  always @(negedge clk) begin
    if (ir_ld === 1'b1) fetches++;
    if (exp_on) begin
      checks++;
      if (dut_vec !== exp_vec) begin
        errors++;
        $display("FAIL cycle_cmp t=%0t ir=%02h got %b want %b", $time, ir, dut_vec, exp_vec);
      end
    end
  end

  task automatic expect_cycle(input int ph);
    exp_vec = model(ph, ir, acc_zero, m_ill);
    exp_on  = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic pin(input string name, input logic [12:0] got, input logic [12:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, got, want);
    end
  endtask

  task automatic tail();
`ifdef CTRL_SEQ_STEP_EN
    step = 1'b0;
    expect_cycle(PH_WAIT);
    step = 1'b1;
    expect_cycle(PH_WAIT);
`endif
  endtask

  task automatic do_instr(input logic [7:0] op, input logic az);
    logic [3:0] o;
    o = op[7:4];
    ir = op;
    acc_zero = az;
    run = 1'($urandom_range(0, 1));
`ifdef CTRL_SEQ_STEP_EN
    step = 1'b0;
`endif
    expect_cycle(PH_FETCH);
    #2;
    if (op == 8'h00) pin("nop_decode", dut_vec, 13'b1_0000_0000_0000);
    if (op == 8'h1A) pin("lda_decode_pc_inc", 13'(pc_inc), 13'd1);
    expect_cycle(PH_DECODE);
    if (o >= 4'h1 && o <= 4'h6) begin
      #2;
      if (op == 8'h1A) pin("lda_oper_mar_ld", {11'd0, mar_ld, mem_rd}, 13'b11);
      expect_cycle(PH_OPER);
      #2;
      if (op == 8'h1A)
        pin("lda_exec", {6'd0, addr_sel, mem_rd, acc_ld, alu_op, pc_inc, mem_wr}, 13'b1110010);
      if (o == 4'h6 && az)  pin("jz_taken", {11'd0, pc_ld, pc_inc}, 13'b10);
      if (o == 4'h6 && !az) pin("jz_not_taken", {11'd0, pc_ld, pc_inc}, 13'b01);
      expect_cycle(PH_EXEC);
    end
    tail();
  endtask

  initial begin
    int f0;
    rst = 1'b1; run = 1'b0; ir = 8'h00; acc_zero = 1'b0;
`ifdef CTRL_SEQ_STEP_EN
    step = 1'b0;
`endif
    @(posedge clk); @(posedge clk); #1;
    #2; pin("reset_outputs", dut_vec, 13'd0);
    expect_cycle(PH_IDLE);
    rst = 1'b0;
    expect_cycle(PH_IDLE);
    expect_cycle(PH_IDLE);
    run = 1'b1;
    expect_cycle(PH_IDLE);

    do_instr(8'h00, 1'b0);
    do_instr(8'h1A, 1'b0);
    do_instr(8'h2B, 1'b1);
    do_instr(8'h3C, 1'b0);
    do_instr(8'h4D, 1'b1);
    do_instr(8'h50, 1'b0);
    do_instr(8'h61, 1'b1);
    do_instr(8'h62, 1'b0);
    do_instr(8'h00, 1'b1);

`ifdef CTRL_SEQ_STEP_EN
    ir = 8'h00; step = 1'b0;
    expect_cycle(PH_FETCH);
    expect_cycle(PH_DECODE);
    f0 = fetches;
    expect_cycle(PH_WAIT);
    expect_cycle(PH_WAIT);
    step = 1'b1;
    expect_cycle(PH_WAIT);
    expect_cycle(PH_FETCH);
    expect_cycle(PH_DECODE);
    expect_cycle(PH_WAIT);
    expect_cycle(PH_WAIT);
    step = 1'b0;
    expect_cycle(PH_WAIT);
    pin("step_hold_one_fetch", 13'(fetches - f0), 13'd1);
    tail();
`else
    f0 = 0;
`endif

    // reset in the middle of STA
    ir = 8'h2C; acc_zero = 1'b0;
`ifdef CTRL_SEQ_STEP_EN
    step = 1'b0;
`endif
    expect_cycle(PH_FETCH);
    expect_cycle(PH_DECODE);
    rst = 1'b1;
    expect_cycle(PH_OPER);
    rst = 1'b0; run = 1'b0;
    #2; pin("rst_mid_sta", dut_vec, 13'd0);
    expect_cycle(PH_IDLE);
    expect_cycle(PH_IDLE);
    run = 1'b1;
    expect_cycle(PH_IDLE);

    // undefined opcode
    ir = 8'h90;
    expect_cycle(PH_FETCH);
    expect_cycle(PH_DECODE);
    m_ill = 1'b1;
    for (int i = 0; i < 4; i++) begin
      run = ~run;
      expect_cycle(PH_HALT);
    end
    #2; pin("illegal_halt", {11'd0, halted, illegal}, 13'b11);
    rst = 1'b1;
    expect_cycle(PH_HALT);
    rst = 1'b0; run = 1'b0; m_ill = 1'b0;
    #2; pin("rst_clears_halt", {11'd0, halted, illegal}, 13'b00);
    expect_cycle(PH_IDLE);
    run = 1'b1;
    expect_cycle(PH_IDLE);

    // HLT
    ir = 8'hF0;
    expect_cycle(PH_FETCH);
    expect_cycle(PH_DECODE);
    for (int i = 0; i < 3; i++) begin
      run = ~run;
      expect_cycle(PH_HALT);
    end
    #2; pin("hlt_halt", {11'd0, halted, illegal}, 13'b10);

    exp_on = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
